siso_shift_register: RTL and testbench

// - Serial-in serial-out shift register: one bit enters per clock, exits WIDTH clocks later.
// - Used as a fixed bit-delay line and as a serial-stream observation point.
// - The full register contents are exported for debug/monitoring.

---
 rtl/siso_shift_register.sv | 62 ++++++
 tb/tb_siso_shift_register.sv | 125 ++++++++++++
 2 files changed

// File: rtl/siso_shift_register.sv
// Serial-in serial-out shift register: a WIDTH-clock bit delay line with its contents exported.
// Define SISO_FILL_FLAG_EN to add the sticky 'filled' output backed by a saturating edge counter.
module siso_shift_register #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] shift_reg
`ifdef SISO_FILL_FLAG_EN
    ,
    output logic             filled
`endif
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    // Newest bit enters at bit 0; the oldest leaves from bit WIDTH-1.
    always_comb begin
        shift_d = {shift_q[WIDTH-2:0], serial_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign shift_reg  = shift_q;
    assign serial_out = shift_q[WIDTH-1];

`ifdef SISO_FILL_FLAG_EN
    localparam int              CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating at WIDTH makes 'filled' sticky without a separate flag register.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign filled = (cnt_q == CNT_MAX);
`endif

endmodule

// File: tb/tb_siso_shift_register.sv
// Directed-vector bench for siso_shift_register (WIDTH=4); checks 'filled' when SISO_FILL_FLAG_EN is defined.
`timescale 1ns/1ps
module tb_siso_shift_register;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             serial_in;
    logic             serial_out;
    logic [WIDTH-1:0] shift_reg;
`ifdef SISO_FILL_FLAG_EN
    logic             filled;
    int               edges_since_rst;
`endif

    int tests;
    int fails;

    siso_shift_register #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .serial_out(serial_out),
        .shift_reg (shift_reg)
`ifdef SISO_FILL_FLAG_EN
        ,
        .filled    (filled)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, clock one rising edge, sample 1 ns later.
    task automatic step(input logic rst_v, input logic din,
                        input logic [WIDTH-1:0] exp_sr, input logic exp_so,
                        input string tag);
        @(negedge clk);
        rst       = rst_v;
        serial_in = din;
        @(posedge clk);
        #1;
        tests++;
        assert (shift_reg === exp_sr) else begin
            fails++;
            $error("FAIL %s shift_reg observed=%b expected=%b", tag, shift_reg, exp_sr);
        end
        tests++;
        assert (serial_out === exp_so) else begin
            fails++;
            $error("FAIL %s serial_out observed=%b expected=%b", tag, serial_out, exp_so);
        end
`ifdef SISO_FILL_FLAG_EN
        if (rst_v) edges_since_rst = 0;
        else       edges_since_rst++;
        tests++;
        assert (filled === (edges_since_rst >= WIDTH)) else begin
            fails++;
            $error("FAIL %s filled observed=%b expected=%b", tag, filled, (edges_since_rst >= WIDTH));
        end
`endif
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        serial_in = 1'b0;
`ifdef SISO_FILL_FLAG_EN
        edges_since_rst = 0;
`endif

        // Reset, including serial_in=1 being ignored while rst is high
        step(1'b1, 1'b0, 4'b0000, 1'b0, "reset0");
        step(1'b1, 1'b1, 4'b0000, 1'b0, "reset_ignore_in");

        // Pattern 1,0,1,1,0
        step(1'b0, 1'b1, 4'b0001, 1'b0, "pat1");
        step(1'b0, 1'b0, 4'b0010, 1'b0, "pat2");
        step(1'b0, 1'b1, 4'b0101, 1'b0, "pat3");
        step(1'b0, 1'b1, 4'b1011, 1'b1, "pat4");
        step(1'b0, 1'b0, 4'b0110, 1'b0, "pat5");

        // Flush with zeros
        step(1'b0, 1'b0, 4'b1100, 1'b1, "flush1");
        step(1'b0, 1'b0, 4'b1000, 1'b1, "flush2");
        step(1'b0, 1'b0, 4'b0000, 1'b0, "flush3");
        step(1'b0, 1'b0, 4'b0000, 1'b0, "flush4");
        step(1'b0, 1'b0, 4'b0000, 1'b0, "flush5");

        // Latency: a lone 1 reaches serial_out after the 4th edge for one cycle
        step(1'b0, 1'b1, 4'b0001, 1'b0, "lat1");
        step(1'b0, 1'b0, 4'b0010, 1'b0, "lat2");
        step(1'b0, 1'b0, 4'b0100, 1'b0, "lat3");
        step(1'b0, 1'b0, 4'b1000, 1'b1, "lat4");
        step(1'b0, 1'b0, 4'b0000, 1'b0, "lat5");

        // Mid-stream reset discards in-flight bits
        step(1'b0, 1'b1, 4'b0001, 1'b0, "mid1");
        step(1'b0, 1'b0, 4'b0010, 1'b0, "mid2");
        step(1'b0, 1'b1, 4'b0101, 1'b0, "mid3");
        step(1'b0, 1'b1, 4'b1011, 1'b1, "mid4");
        step(1'b1, 1'b1, 4'b0000, 1'b0, "mid_rst");
        step(1'b0, 1'b1, 4'b0001, 1'b0, "mid_resume");

        // Fresh reset then ten shift edges: all-ones fill, then zeros drain
        step(1'b1, 1'b0, 4'b0000, 1'b0, "fill_rst");
        step(1'b0, 1'b1, 4'b0001, 1'b0, "fill1");
        step(1'b0, 1'b1, 4'b0011, 1'b0, "fill2");
        step(1'b0, 1'b1, 4'b0111, 1'b0, "fill3");
        step(1'b0, 1'b1, 4'b1111, 1'b1, "fill4");
        step(1'b0, 1'b0, 4'b1110, 1'b1, "fill5");
        step(1'b0, 1'b0, 4'b1100, 1'b1, "fill6");
        step(1'b0, 1'b0, 4'b1000, 1'b1, "fill7");
        step(1'b0, 1'b0, 4'b0000, 1'b0, "fill8");
        step(1'b0, 1'b0, 4'b0000, 1'b0, "fill9");
        step(1'b0, 1'b0, 4'b0000, 1'b0, "fill10");
        step(1'b1, 1'b1, 4'b0000, 1'b0, "fill_clear");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
